// File: rtl/ctr_seq_pkg.sv
// Shared types and widths for the counter sweep sequencer.
// Holds the FSM state enum and the counter datapath widths.
package ctr_seq_pkg;

  localparam int CNT_W  = 8;
  localparam int LOAD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

endpackage

// File: rtl/counter_sweep_ctrl_step_prescaler.sv
// Step-rate divider: tick once every div+1 cycles while run is high.
// Ports: clk, rst_n, clear (sync zero), run, div -> tick.
module step_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               run,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  assign tick = run && (count == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer driving an 8-bit up/down counter through up or ping-pong sweeps.
// Ports: start/stop + latched config in; cnt_* control, busy/done/aborted/sweeps_done out.
module counter_sweep_ctrl
  import ctr_seq_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [LOAD_W-1:0]  start_val,
  input  logic [CNT_W-1:0]   limit,
  input  logic               pingpong,
  input  logic [3:0]         reps,
  input  logic [PRESC_W-1:0] div,
  input  logic [CNT_W-1:0]   cnt_value,
  output logic               cnt_load,
  output logic [LOAD_W-1:0]  cnt_load_val,
  output logic               cnt_enable,
  output logic               cnt_dir_up,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [3:0]         sweeps_done
);

  state_t state, state_n;

  logic [LOAD_W-1:0]  sv_q;
  logic [CNT_W-1:0]   lim_q;
  logic               pp_q;
  logic [3:0]         reps_q;
  logic [PRESC_W-1:0] div_q;

  logic       at_lim, at_start;
  logic       run, tick;
  logic       accept, sweep_end;
  logic [3:0] sweeps_inc;

  assign at_lim     = cnt_value >= lim_q;
  assign at_start   = cnt_value <= {{(CNT_W-LOAD_W){1'b0}}, sv_q};
  assign sweeps_inc = sweeps_done + 4'd1;
  assign busy       = state != S_IDLE;

  // Prescaler only counts while a step is actually pending;
  // at turn points, abort and outside UP/DOWN it sits at zero.
  assign run = !stop &&
               ((state == S_UP && !at_lim) ||
                (state == S_DOWN && !at_start));

  step_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run),
    .run   (run),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_n      = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_enable   = 1'b0;
    cnt_dir_up   = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;
    sweep_end    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          accept  = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_load     = 1'b1;
        cnt_load_val = sv_q;
        state_n      = S_UP;
      end
      S_UP: begin
        cnt_dir_up = 1'b1;
        if (at_lim) begin
          if (pp_q) state_n = S_DOWN;
          else      sweep_end = 1'b1;
        end else begin
          cnt_enable = tick;
        end
      end
      S_DOWN: begin
        if (at_start) sweep_end = 1'b1;
        else          cnt_enable = tick;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (sweep_end) begin
      if (sweeps_inc == reps_q) state_n = S_DONE;
      else if (pp_q)            state_n = S_UP;
      else                      state_n = S_LOAD;
    end

    // Abort wins: nothing reaches the counter this cycle.
    if (stop && state != S_IDLE) begin
      cnt_load   = 1'b0;
      cnt_enable = 1'b0;
      done       = 1'b0;
      sweep_end  = 1'b0;
      state_n    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q        <= '0;
      lim_q       <= '0;
      pp_q        <= 1'b0;
      reps_q      <= '0;
      div_q       <= '0;
      sweeps_done <= '0;
      aborted     <= 1'b0;
    end else begin
      if (accept) begin
        sv_q        <= start_val;
        lim_q       <= limit;
        pp_q        <= pingpong;
        reps_q      <= (reps == 4'd0) ? 4'd1 : reps;
        div_q       <= div;
        sweeps_done <= '0;
        aborted     <= 1'b0;
      end else if (sweep_end) begin
        sweeps_done <= sweeps_inc;
      end
      if (stop && state != S_IDLE) begin
        aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl with a behavioural counter.
// Expected counter-control events are queued by stimulus, popped by the monitor.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop;
  logic [3:0] start_val;
  logic [7:0] limit;
  logic       pingpong;
  logic [3:0] reps;
  logic [3:0] div;
  logic [7:0] cnt_value = 8'd0;
  logic       cnt_load;
  logic [3:0] cnt_load_val;
  logic       cnt_enable, cnt_dir_up;
  logic       busy, done, aborted;
  logic [3:0] sweeps_done;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.PRESC_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .start_val    (start_val),
    .limit        (limit),
    .pingpong     (pingpong),
    .reps         (reps),
    .div          (div),
    .cnt_value    (cnt_value),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_enable   (cnt_enable),
    .cnt_dir_up   (cnt_dir_up),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .sweeps_done  (sweeps_done)
  );

  always @(posedge clk) begin
    if (cnt_load)        cnt_value <= {4'b0, cnt_load_val};
    else if (cnt_enable) cnt_value <= cnt_dir_up ? cnt_value + 8'd1
                                                 : cnt_value - 8'd1;
  end

  typedef struct packed {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic       dn;
    logic [3:0] sd;
    logic [7:0] cv;
    logic [7:0] gap;
  } ev_t;

  ev_t expq[$];
  ev_t mon_o, mon_e;
  int  compared = 0;
  int  mismatched = 0;
  int  gap = 0;

  function automatic ev_t mk(logic ld, logic [3:0] lv, logic en,
                             logic up, logic dn, logic [3:0] sd,
                             logic [7:0] cv, logic [7:0] g);
    ev_t e;
    e = '{ld, lv, en, up, dn, sd, cv, g};
    return e;
  endfunction

  task automatic exp_load(input logic [3:0] lv);
    expq.push_back(mk(1'b1, lv, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0));
  endtask

  task automatic exp_step(input logic up, input logic [3:0] sd,
                          input logic [7:0] cv, input logic [7:0] g);
    expq.push_back(mk(1'b0, 4'd0, 1'b1, up, 1'b0, sd, cv, g));
  endtask

  task automatic exp_done(input logic [3:0] sd, input logic [7:0] cv,
                          input logic [7:0] g);
    expq.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, sd, cv, g));
  endtask

  // gap = cycles since previous event; 0 in the expectation means don't care.
  always @(negedge clk) begin
    if (!rst_n) begin
      gap = 0;
    end else begin
      gap++;
      if (cnt_load || cnt_enable || done) begin
        mon_o = mk(cnt_load, cnt_load_val, cnt_enable, cnt_dir_up, done,
                   sweeps_done, cnt_load ? 8'd0 : cnt_value, gap[7:0]);
        gap = 0;
        compared++;
        if (expq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event got=%h required=none t=%0t",
                   mon_o, $time);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.gap == 8'd0) mon_o.gap = 8'd0;
          if (mon_o !== mon_e) begin
            mismatched++;
            $display("FAIL event got=%h required=%h t=%0t",
                     mon_o, mon_e, $time);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s got=%0h required=%0h t=%0t", name, got, req, $time);
    end
  endtask

  task automatic kick(input logic [3:0] sv, input logic [7:0] lim,
                      input logic pp, input logic [3:0] rp,
                      input logic [3:0] dv);
    @(posedge clk); #1;
    start_val = sv;
    limit     = lim;
    pingpong  = pp;
    reps      = rp;
    div       = dv;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_abort_clr", {31'd0, aborted}, 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget,
                           input int req);
    int n;
    n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
    chk(name, n, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    start_val = '0;
    limit = '0;
    pingpong = 1'b0;
    reps = '0;
    div = '0;
    #3;
    chk("reset_outs",
        {cnt_load, cnt_load_val, cnt_enable, cnt_dir_up,
         busy, done, aborted, sweeps_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single up sweep, div=0.
    exp_load(4'd3);
    exp_step(1'b1, 4'd0, 8'd3, 8'd1);
    exp_step(1'b1, 4'd0, 8'd4, 8'd1);
    exp_step(1'b1, 4'd0, 8'd5, 8'd1);
    exp_done(4'd1, 8'd6, 8'd2);
    kick(4'd3, 8'd6, 1'b0, 4'd1, 4'd0);
    wait_idle("t1_idle_cycle", 50, 6);
    chk("t1_cnt", cnt_value, 8'd6);
    chk("t1_sweeps", sweeps_done, 4'd1);

    // Ping-pong, two sweeps.
    exp_load(4'd2);
    exp_step(1'b1, 4'd0, 8'd2, 8'd1);
    exp_step(1'b1, 4'd0, 8'd3, 8'd1);
    exp_step(1'b0, 4'd0, 8'd4, 8'd2);
    exp_step(1'b0, 4'd0, 8'd3, 8'd1);
    exp_step(1'b1, 4'd1, 8'd2, 8'd2);
    exp_step(1'b1, 4'd1, 8'd3, 8'd1);
    exp_step(1'b0, 4'd1, 8'd4, 8'd2);
    exp_step(1'b0, 4'd1, 8'd3, 8'd1);
    exp_done(4'd2, 8'd2, 8'd2);
    kick(4'd2, 8'd4, 1'b1, 4'd2, 4'd0);
    wait_idle("t2_idle_cycle", 80, 14);
    chk("t2_cnt", cnt_value, 8'd2);
    chk("t2_sweeps", sweeps_done, 4'd2);

    // Prescaled: one step every 3 cycles.
    exp_load(4'd0);
    exp_step(1'b1, 4'd0, 8'd0, 8'd3);
    exp_step(1'b1, 4'd0, 8'd1, 8'd3);
    exp_done(4'd1, 8'd2, 8'd2);
    kick(4'd0, 8'd2, 1'b0, 4'd1, 4'd2);
    wait_idle("t3_idle_cycle", 80, 9);
    chk("t3_cnt", cnt_value, 8'd2);

    // Abort mid-UP at counter 5.
    exp_load(4'd1);
    exp_step(1'b1, 4'd0, 8'd1, 8'd1);
    exp_step(1'b1, 4'd0, 8'd2, 8'd1);
    exp_step(1'b1, 4'd0, 8'd3, 8'd1);
    exp_step(1'b1, 4'd0, 8'd4, 8'd1);
    kick(4'd1, 8'd20, 1'b0, 4'd1, 4'd0);
    for (int i = 0; i < 20; i++) begin
      if (cnt_value == 8'd5) break;
      @(posedge clk); #1;
    end
    chk("t4_reach5", cnt_value, 8'd5);
    stop = 1'b1;
    #2;
    chk("t4_cut", {30'd0, cnt_load, cnt_enable}, 32'd0);
    @(posedge clk); #1;
    stop = 1'b0;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_aborted", {31'd0, aborted}, 32'd1);
    chk("t4_sweeps", sweeps_done, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_cnt_hold", cnt_value, 8'd5);
    chk("t4_abort_sticky", {31'd0, aborted}, 32'd1);

    // limit below start, reps=0 acts as 1.
    exp_load(4'd9);
    exp_done(4'd1, 8'd9, 8'd2);
    kick(4'd9, 8'd1, 1'b0, 4'd0, 4'd0);
    wait_idle("t5_idle_cycle", 20, 3);
    chk("t5_cnt", cnt_value, 8'd9);

    // Async reset during DOWN.
    exp_load(4'd2);
    exp_step(1'b1, 4'd0, 8'd2, 8'd1);
    exp_step(1'b1, 4'd0, 8'd3, 8'd1);
    exp_step(1'b1, 4'd0, 8'd4, 8'd1);
    exp_step(1'b0, 4'd0, 8'd5, 8'd2);
    kick(4'd2, 8'd5, 1'b1, 4'd1, 4'd0);
    for (int i = 0; i < 20; i++) begin
      if (!cnt_dir_up && cnt_value == 8'd4) break;
      @(posedge clk); #1;
    end
    chk("t6_in_down", {23'd0, busy, cnt_value}, {23'd0, 1'b1, 8'd4});
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outs",
        {cnt_load, cnt_load_val, cnt_enable, cnt_dir_up,
         busy, done, aborted, sweeps_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Normal run after reset; start and config churn mid-run ignored.
    exp_load(4'd3);
    exp_step(1'b1, 4'd0, 8'd3, 8'd1);
    exp_step(1'b1, 4'd0, 8'd4, 8'd1);
    exp_step(1'b1, 4'd0, 8'd5, 8'd1);
    exp_done(4'd1, 8'd6, 8'd2);
    kick(4'd3, 8'd6, 1'b0, 4'd1, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    limit = 8'd200;
    pingpong = 1'b1;
    reps = 4'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t7_idle_cycle", 20, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("t7_stay_idle", {31'd0, busy}, 32'd0);
    chk("t7_cnt", cnt_value, 8'd6);

    chk("queue_drained", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the 8-bit up/down counter datapath (load / enable / dir_up / 4-bit load value).
- On a start command it loads a start value, then steps the counter up to a limit.
- In ping-pong mode it then steps back down to the start value.
- It repeats for a programmed number of sweeps at a prescaled step rate.
- Sits between the host-facing config pins and the counter; watches the counter value to decide each cycle.

Parameters:
PRESC_W, 4, width of step-rate divider input and prescaler counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  level; accepted only in IDLE, latches config
stop  in  1  abort; priority over everything except reset
start_val  in  4  counter load value (zero-extended to 8 bits)
limit  in  8  upper turn/finish point
pingpong  in  1  1 = up then down per sweep; 0 = up only, reload per sweep
reps  in  4  sweeps to run; 0 treated as 1
div  in  PRESC_W  one step every div+1 cycles
cnt_value  in  8  current counter value (feedback)
cnt_load  out  1  counter load strobe
cnt_load_val  out  4  value to load
cnt_enable  out  1  counter step enable
cnt_dir_up  out  1  1 = increment
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse at normal completion
aborted  out  1  sticky; set by stop while busy, cleared by next accepted start
sweeps_done  out  4  completed sweeps in current run

Behaviour:
- Reset:
  - state IDLE; prescaler 0.
  - All outputs 0; sweeps_done 0; latched config 0.
- States and transitions:
  - IDLE --start & !stop--> LOAD. Latch start_val, limit, pingpong, reps (0→1) and div; clear sweeps_done and aborted.
  - LOAD: cnt_load=1, cnt_load_val=latched start_val for exactly one cycle; prescaler cleared. Next state UP.
  - UP: cnt_dir_up=1.
    - If cnt_value >= limit: cnt_enable=0, turn point reached.
      - pingpong=1 → DOWN.
      - pingpong=0 → sweep complete.
    - Else cnt_enable=tick.
  - DOWN: cnt_dir_up=0.
    - If cnt_value <= {4'b0,start_val}: cnt_enable=0, sweep complete.
    - Else cnt_enable=tick.
  - Sweep complete: sweeps_done increments.
    - If new sweeps_done == reps → DONE.
    - Else pingpong → UP; single → LOAD.
  - DONE: done=1 for one cycle, busy=1; next state IDLE.
- Prescaler:
  - Counts 0..div in UP/DOWN only.
  - tick=1 when count==div, then count wraps to 0.
  - div=0 → tick every cycle.
  - Prescaler is held at 0 when cnt_enable is suppressed at a turn point.
- Outputs:
  - cnt_* are combinational from state, tick, cnt_value.
  - Counter changes at the edge following a cycle with cnt_enable=1; controller sees the new value the next cycle. Never overshoots.
- Compare rule: >= / <= handle limit <= start_val. UP completes immediately with no steps; counter never wraps past 255 or 0 under controller.
- stop while busy:
  - cnt_load and cnt_enable forced 0 in that same cycle; next state IDLE.
  - aborted=1; no done pulse; counter keeps its value; sweeps_done holds.
- start while busy: ignored. start & stop together in IDLE: nothing happens.
- Config input changes during a run: no effect (latched values used).
- Async reset mid-run: immediate IDLE, outputs 0; counter state is the counter's own concern.

Decomposition:
- Shared package ctr_seq_pkg:
  - state enum (IDLE, LOAD, UP, DOWN, DONE).
  - CNT_W=8, LOAD_W=4 constants.
- One natural sub-module: step_prescaler (div counter with clear and tick output).
- FSM and compare logic stay in counter_sweep_ctrl.

Test Plan:
- start_val=3, limit=6, pingpong=0, reps=1, div=0; start at cycle 0 →
  - cycle 1: cnt_load=1, val 3.
  - cycles 2-4: cnt_enable=1, dir_up=1.
  - counter 6 at cycle 5, enable=0.
  - cycle 6: done pulse; busy falls cycle 7; sweeps_done=1.
- start_val=2, limit=4, pingpong=1, reps=2, div=0 → counter sequence 2,3,4,3,2,3,4,3,2.
  - One load only; sweeps_done 1 then 2; single done pulse.
- div=2, start_val=0, limit=2 → cnt_enable high one cycle in three; counter reaches 2 after 6 UP cycles.
- stop asserted mid-UP with counter at 5 → cnt_enable=0 same cycle; IDLE next cycle; aborted=1; no done; counter stays 5; new start clears aborted.
- limit=1, start_val=9 → LOAD, then UP exits immediately with zero enables; done; counter 9.
- rst_n pulsed low during DOWN → all outputs 0 asynchronously; busy=0; later start runs normally; start pulses during a run are ignored.
